// File: rtl/codificador_pkg.sv
// Shared constants, segment table and Gray helper for the Gray-code encoder
// and its seven-segment display decoder.
package codificador_pkg;

  localparam int unsigned DATA_W = 4;
  localparam int unsigned SEG_W  = 7;

  // Active-high abcdefg patterns, indexed by hex digit (entry 15 listed first).
  localparam logic [15:0][SEG_W-1:0] SEG_TABLE = '{
    7'b1000111,  // F
    7'b1001111,  // E
    7'b0111101,  // d
    7'b1001110,  // C
    7'b0011111,  // b
    7'b1110111,  // A
    7'b1111011,  // 9
    7'b1111111,  // 8
    7'b1110000,  // 7
    7'b1011111,  // 6
    7'b1011011,  // 5
    7'b0110011,  // 4
    7'b1111001,  // 3
    7'b1101101,  // 2
    7'b0110000,  // 1
    7'b1111110   // 0
  };

  function automatic logic [DATA_W-1:0] gray_encode(input logic [DATA_W-1:0] bin);
    return bin ^ (bin >> 1);
  endfunction

endpackage

// File: rtl/display_decoder.sv
// Combinational hex-digit to seven-segment decoder (abcdefg, a = MSB).
module display_decoder
  import codificador_pkg::*;
#(
  parameter bit SEG_ACTIVE_LOW = 1'b0
) (
  input  logic [DATA_W-1:0] value,
  output logic [SEG_W-1:0]  segments
);

  always_comb begin
    segments = SEG_TABLE[value];
    if (SEG_ACTIVE_LOW) begin
      segments = ~SEG_TABLE[value];
    end
  end

endmodule

// File: rtl/codificador_display.sv
// Registered 4-bit binary-to-Gray encoder whose output is also shown on a
// seven-segment display; the Output register is the only state.
module codificador_display
  import codificador_pkg::*;
#(
  parameter bit SEG_ACTIVE_LOW = 1'b0
) (
  input  logic              Clock,
  input  logic              Reset,
  input  logic [DATA_W-1:0] Input,
  input  logic              Ready,
  output logic [DATA_W-1:0] Output,
  output logic [SEG_W-1:0]  Display
);

  logic [DATA_W-1:0] code_d;
  logic [DATA_W-1:0] code_q;

  always_comb begin
    code_d = code_q;
    if (Ready) begin
      code_d = gray_encode(Input);
    end
  end

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      code_q <= '0;
    end else begin
      code_q <= code_d;
    end
  end

  assign Output = code_q;

  // Display follows the register directly, so it tracks reset without a clock.
  display_decoder #(
    .SEG_ACTIVE_LOW(SEG_ACTIVE_LOW)
  ) u_display_decoder (
    .value   (code_q),
    .segments(Display)
  );

endmodule

// File: tb/tb_codificador_display.sv
// Directed bench for codificador_display: a common-cathode and a common-anode
// instance share stimulus; expected values are hand-computed.
module tb_codificador_display;

  logic       Clock;
  logic       Reset;
  logic [3:0] Input;
  logic       Ready;
  logic [3:0] out_hi;
  logic [6:0] disp_hi;
  logic [3:0] out_lo;
  logic [6:0] disp_lo;

  int errors = 0;
  int checks = 0;

  codificador_display #(.SEG_ACTIVE_LOW(1'b0)) dut_hi (
    .Clock  (Clock),
    .Reset  (Reset),
    .Input  (Input),
    .Ready  (Ready),
    .Output (out_hi),
    .Display(disp_hi)
  );

  codificador_display #(.SEG_ACTIVE_LOW(1'b1)) dut_lo (
    .Clock  (Clock),
    .Reset  (Reset),
    .Input  (Input),
    .Ready  (Ready),
    .Output (out_lo),
    .Display(disp_lo)
  );

  initial begin
    Clock = 1'b0;
    forever #5 Clock = ~Clock;
  end

  function automatic logic [6:0] seg_of(input logic [3:0] v);
    case (v)
      4'h0: return 7'b1111110;
      4'h1: return 7'b0110000;
      4'h2: return 7'b1101101;
      4'h3: return 7'b1111001;
      4'h4: return 7'b0110011;
      4'h5: return 7'b1011011;
      4'h6: return 7'b1011111;
      4'h7: return 7'b1110000;
      4'h8: return 7'b1111111;
      4'h9: return 7'b1111011;
      4'hA: return 7'b1110111;
      4'hB: return 7'b0011111;
      4'hC: return 7'b1001110;
      4'hD: return 7'b0111101;
      4'hE: return 7'b1001111;
      default: return 7'b1000111;
    endcase
  endfunction

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  task automatic test_reset();
    Reset = 1'b1;
    Ready = 1'b1;
    Input = 4'b1010;
    #1 Reset = 1'b0;
    #2;  // t=3, before the first rising edge
    checks++;
    if (out_hi !== 4'b0000) begin
      errors++;
      $display("FAIL reset_output got=%b exp=0000", out_hi);
    end
    checks++;
    if (disp_hi !== 7'b1111110) begin
      errors++;
      $display("FAIL reset_display got=%b exp=1111110", disp_hi);
    end
    checks++;
    if (disp_lo !== 7'b0000001) begin
      errors++;
      $display("FAIL reset_display_active_low got=%b exp=0000001", disp_lo);
    end
    tick();
    checks++;
    if (out_hi !== 4'b0000) begin
      errors++;
      $display("FAIL reset_priority_over_ready got=%b exp=0000", out_hi);
    end
  endtask

  task automatic test_release();
    @(negedge Clock);
    Reset = 1'b1;
    Ready = 1'b1;
    Input = 4'b0101;
    tick();
    checks++;
    if (out_hi !== 4'b0111) begin
      errors++;
      $display("FAIL first_load_output got=%b exp=0111", out_hi);
    end
    checks++;
    if (disp_hi !== 7'b1110000) begin
      errors++;
      $display("FAIL first_load_display got=%b exp=1110000", disp_hi);
    end
    checks++;
    if (disp_lo !== 7'b0001111) begin
      errors++;
      $display("FAIL first_load_display_active_low got=%b exp=0001111", disp_lo);
    end
  endtask

  task automatic test_hold();
    Ready = 1'b1;
    Input = 4'b1111;
    tick();
    checks++;
    if (out_hi !== 4'b1000 || disp_hi !== 7'b1111111) begin
      errors++;
      $display("FAIL load_1111 got=%b/%b exp=1000/1111111", out_hi, disp_hi);
    end
    Ready = 1'b0;
    Input = 4'b0110;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (out_hi !== 4'b1000 || disp_hi !== 7'b1111111) begin
        errors++;
        $display("FAIL hold_edge%0d got=%b/%b exp=1000/1111111", i, out_hi, disp_hi);
      end
    end
  endtask

  task automatic test_hex();
    Ready = 1'b1;
    Input = 4'b1100;
    tick();
    checks++;
    if (out_hi !== 4'b1010 || disp_hi !== 7'b1110111) begin
      errors++;
      $display("FAIL load_1100 got=%b/%b exp=1010/1110111", out_hi, disp_hi);
    end
    Input = 4'b1001;
    tick();
    checks++;
    if (out_hi !== 4'b1101 || disp_hi !== 7'b0111101) begin
      errors++;
      $display("FAIL load_1001 got=%b/%b exp=1101/0111101", out_hi, disp_hi);
    end
  endtask

  task automatic test_sweep();
    logic [3:0] v;
    logic [3:0] g;
    Ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      v = 4'(i);
      g = {v[3], v[3] ^ v[2], v[2] ^ v[1], v[1] ^ v[0]};
      Input = v;
      tick();
      checks++;
      if (out_hi !== g || disp_hi !== seg_of(g)) begin
        errors++;
        $display("FAIL sweep_in%0d got=%b/%b exp=%b/%b", i, out_hi, disp_hi, g, seg_of(g));
      end
      checks++;
      if (out_lo !== g || disp_lo !== ~seg_of(g)) begin
        errors++;
        $display("FAIL sweep_active_low_in%0d got=%b/%b exp=%b/%b",
                 i, out_lo, disp_lo, g, ~seg_of(g));
      end
    end
  endtask

  task automatic test_async_reset();
    Ready = 1'b1;
    Input = 4'b0101;
    tick();
    @(negedge Clock);
    #2 Reset = 1'b0;
    #1;  // still well before the next rising edge
    checks++;
    if (out_hi !== 4'b0000 || disp_hi !== 7'b1111110) begin
      errors++;
      $display("FAIL async_reset got=%b/%b exp=0000/1111110", out_hi, disp_hi);
    end
    @(negedge Clock);
    Reset = 1'b1;
  endtask

  task automatic test_active_low_zero();
    Ready = 1'b1;
    Input = 4'b1110;
    tick();
    Input = 4'b0000;
    tick();
    checks++;
    if (out_lo !== 4'b0000 || disp_lo !== 7'b0000001) begin
      errors++;
      $display("FAIL active_low_zero got=%b/%b exp=0000/0000001", out_lo, disp_lo);
    end
  endtask

  initial begin
    test_reset();
    test_release();
    test_hold();
    test_hex();
    test_sweep();
    test_async_reset();
    test_active_low_zero();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/codificador_display.md
CODIFICADOR_DISPLAY -- requirements
Module: codificador_display

Interface
REQ-001 SHALL have parameter SEG_ACTIVE_LOW, default 0; 0 = segment lit by 1 (common cathode), 1 = every Display bit inverted (common anode).
REQ-002 SHALL have port Clock  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port Reset  input  1  asynchronous, active-low reset (0 = reset asserted).
REQ-004 SHALL have port Input  input  4  binary value to encode, Input[3] MSB.
REQ-005 SHALL have port Ready  input  1  load enable; 1 = capture and encode Input this edge.
REQ-006 SHALL have port Output  output  4  registered Gray-coded value, Output[3] MSB.
REQ-007 SHALL have port Display  output  7  seven-segment pattern of Output; Display[6..0] = segments a,b,c,d,e,f,g.

Function
REQ-008 SHALL compute code as Gray: Output[3] = Input[3]; Output[i] = Input[i+1] XOR Input[i] for i = 2..0.
REQ-009 SHALL, on a rising Clock edge with Ready=1, load Output with the Gray code of Input (latency 1 cycle).
REQ-010 SHALL, on a rising Clock edge with Ready=0, hold Output unchanged.
REQ-011 SHALL drive Display combinationally from registered Output (same cycle as Output; no added latency).
REQ-012 SHALL decode Output as a hex digit (active-high, abcdefg): 0=1111110, 1=0110000, 2=1101101, 3=1111001, 4=0110011, 5=1011011, 6=1011111, 7=1110000.
REQ-013 SHALL decode: 8=1111111, 9=1111011, A=1110111, b=0011111, C=1001110, d=0111101, E=1001111, F=1000111.
REQ-014 SHALL, when SEG_ACTIVE_LOW=1, output the bitwise inverse of the REQ-012/013 patterns.
REQ-015 SHALL treat all 16 Input values as valid; no illegal codes, no wrap-around state.
REQ-016 SHALL give Reset priority over Ready: Reset=0 forces reset values regardless of Ready or Clock.
REQ-017 SHALL, on the first rising edge after Reset deasserts with Ready=1, load normally (no dead cycle).
REQ-018 SHALL have no X/Z on Output or Display after reset for any Input value.

Reset
REQ-019 SHALL, while Reset=0, asynchronously force Output=0000.
REQ-020 SHALL, while Reset=0, show Display = digit 0 pattern (1111110, or 0000001 if SEG_ACTIVE_LOW=1).
REQ-021 SHALL, on Reset asserted mid-operation, clear Output immediately without waiting for Clock.

Structure
REQ-022 SHALL place the 16-entry segment pattern table, DATA_W=4 and SEG_W=7 constants in shared package codificador_pkg.
REQ-023 SHALL implement the hex-to-segment decode as one combinational sub-module display_decoder (in: 4-bit value, parameter SEG_ACTIVE_LOW; out: 7-bit segments).
REQ-024 SHALL keep the Gray encoder and Output register in the top module; the register is the only state element.

Verification
REQ-025 SHALL cover: Reset=0 with Input=1010, Ready=1 -> Output=0000, Display=1111110 with no clock edge needed.
REQ-026 SHALL cover: Ready=1, Input=0101, one edge -> Output=0111, Display=1110000.
REQ-027 SHALL cover: Ready=1, Input=1111 -> Output=1000, Display=1111111; then Ready=0, Input=0110, edges -> Output stays 1000.
REQ-028 SHALL cover: Ready=1, Input=1100 -> Output=1010, Display=1110111; Input=1001 -> Output=1101, Display=0111101.
REQ-029 SHALL cover: sweep Input 0..15 with Ready=1, 10 time units per step -> each Output equals Gray(Input) one edge later, Display matches REQ-012/013.
REQ-030 SHALL cover: SEG_ACTIVE_LOW=1, Input=0000 loaded -> Display=0000001.
